// File: rtl/vfd_video_pkg.sv
// Shared definitions for the VFD video scan-out path.
// Holds the default 640x480@60 timing, frame totals, framebuffer size and
// the RGB332 -> RGB888 expansion used by the scan-out stage (and any later
// overlay/OSD stage that needs the same colour mapping).
package vfd_video_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned H_TOTAL   = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL   = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned FB_PIXELS = DEF_H_ACTIVE * DEF_V_ACTIVE;

  // Bit replication keeps full-scale codes at full scale (7 -> FF, 3 -> FF).
  function automatic logic [23:0] rgb332_to_rgb888(input logic [7:0] d);
    return {d[7:5], d[7:5], d[7:6],
            d[4:2], d[4:2], d[4:3],
            {4{d[1:0]}}};
  endfunction

endpackage

// File: rtl/vfd_video_out_if.sv
// Framebuffer VRAM read port between the scan-out stage and the VRAM.
//   vram_addr : 19-bit linear read address (y*H_ACTIVE + x)
//   vram_data : RGB332 read data, valid 1 clk after vram_addr changes
// master = scan-out (drives the address), slave = VRAM (returns data).
interface vfd_video_out_if;
  logic [18:0] vram_addr;
  logic [7:0]  vram_data;

  modport master (output vram_addr, input vram_data);
  modport slave  (input vram_addr, output vram_data);
endinterface

// File: rtl/vfd_video_timing.sv
// Raster timing generator for the VFD scan-out.
// Runs hcnt/vcnt on ce_pix ticks, computes sync/blank windows into stage-1
// registers, then advances them to the output registers one tick later so
// they line up with the colour captured in the top level.
// Ports:
//   clk, reset (sync, active high), ce_pix (pixel tick)
//   cur_active  : current counter position is inside the visible area
//   at_origin   : counters sit at h=0, v=0
//   s1_de       : stage-1 display enable (gates colour at output)
//   s1_odd      : stage-1 line parity (vcnt[0])
//   hsync, vsync, hblank, vblank, de, frame_start : registered outputs
module vfd_video_timing import vfd_video_pkg::*; #(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic reset,
  input  logic ce_pix,
  output logic cur_active,
  output logic at_origin,
  output logic s1_de,
  output logic s1_odd,
  output logic hsync,
  output logic vsync,
  output logic hblank,
  output logic vblank,
  output logic de,
  output logic frame_start
);

  localparam logic [9:0] HA  = 10'(H_ACTIVE);
  localparam logic [9:0] HS0 = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS1 = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] HL  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VA  = 10'(V_ACTIVE);
  localparam logic [9:0] VS0 = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS1 = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] VL  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [9:0] hcnt, vcnt;
  logic       s1_valid, s1_hblank, s1_vblank, s1_hsync, s1_vsync, s1_fs;

  assign cur_active = (hcnt < HA) && (vcnt < VA);
  assign at_origin  = (hcnt == 10'd0) && (vcnt == 10'd0);
  assign s1_de      = s1_valid && !s1_hblank && !s1_vblank;

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt        <= '0;
      vcnt        <= '0;
      s1_valid    <= 1'b0;
      s1_hblank   <= 1'b1;
      s1_vblank   <= 1'b1;
      s1_hsync    <= 1'b1;
      s1_vsync    <= 1'b1;
      s1_fs       <= 1'b0;
      s1_odd      <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // Pulse lasts exactly one clk: ticks are never on adjacent clks.
      frame_start <= 1'b0;
      if (ce_pix) begin
        hcnt <= (hcnt == HL) ? 10'd0 : hcnt + 10'd1;
        if (hcnt == HL)
          vcnt <= (vcnt == VL) ? 10'd0 : vcnt + 10'd1;

        s1_valid  <= 1'b1;
        s1_hblank <= (hcnt >= HA);
        s1_vblank <= (vcnt >= VA);
        s1_hsync  <= !((hcnt >= HS0) && (hcnt < HS1));
        s1_vsync  <= !((vcnt >= VS0) && (vcnt < VS1));
        s1_fs     <= at_origin;
        s1_odd    <= vcnt[0];

        hsync       <= s1_hsync;
        vsync       <= s1_vsync;
        hblank      <= s1_hblank;
        vblank      <= s1_vblank;
        de          <= s1_de;
        frame_start <= s1_valid && s1_fs;
      end
    end
  end

endmodule

// File: rtl/vfd_video_out.sv
// VFD video scan-out stage (top).
// Reads RGB332 pixels from the compositor framebuffer, expands them to
// RGB888 and drives 640x480@60 video with syncs, blanking and DE.
// Two-tick pipeline: tick n registers the address for (hcnt,vcnt), tick n+1
// captures the VRAM data together with the matching timing flags.
// Ports:
//   clk, reset (sync, active high), ce_pix (pixel tick, at most every 2nd clk)
//   vram        : framebuffer read port (master side)
//   scanlines   : dim odd lines when VFD_VIDEO_SCANLINE_EN is defined
//   r, g, b     : 8-bit colour, zero outside the active area
//   hsync, vsync: negative-polarity syncs
//   hblank, vblank, de, frame_start
// Build option: VFD_VIDEO_SCANLINE_EN enables scanline dimming; without it
// the scanlines input is ignored.
module vfd_video_out import vfd_video_pkg::*; #(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce_pix,
  vfd_video_out_if.master        vram,
  input  logic                   scanlines,
  output logic [7:0]             r,
  output logic [7:0]             g,
  output logic [7:0]             b,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   hblank,
  output logic                   vblank,
  output logic                   de,
  output logic                   frame_start
);

  logic        cur_active, at_origin, s1_de, s1_odd;
  logic [18:0] addr_q;
  logic [23:0] pix;

  vfd_video_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .ce_pix      (ce_pix),
    .cur_active  (cur_active),
    .at_origin   (at_origin),
    .s1_de       (s1_de),
    .s1_odd      (s1_odd),
    .hsync       (hsync),
    .vsync       (vsync),
    .hblank      (hblank),
    .vblank      (vblank),
    .de          (de),
    .frame_start (frame_start)
  );

  // Running linear address: +1 per visible pixel, held through blanking so
  // it parks on the last visible address and never passes the frame size.
  always_ff @(posedge clk) begin
    if (reset)
      addr_q <= '0;
    else if (ce_pix) begin
      if (at_origin)
        addr_q <= '0;
      else if (cur_active)
        addr_q <= addr_q + 19'd1;
    end
  end

  assign vram.vram_addr = addr_q;

  always_comb begin
    pix = rgb332_to_rgb888(vram.vram_data);
`ifdef VFD_VIDEO_SCANLINE_EN
    if (scanlines && s1_odd)
      pix = {1'b0, pix[23:17], 1'b0, pix[15:9], 1'b0, pix[7:1]};
`endif
  end

`ifndef VFD_VIDEO_SCANLINE_EN
  logic unused_scan;
  assign unused_scan = scanlines ^ s1_odd;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      {r, g, b} <= '0;
    else if (ce_pix)
      {r, g, b} <= s1_de ? pix : 24'd0;
  end

endmodule

// File: tb/tb_vfd_video_out.sv
module tb_vfd_video_out;

`ifdef VFD_VIDEO_SCANLINE_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif

  typedef struct packed {
    logic [23:0] rgb;
    logic [18:0] addr;
    logic [5:0]  flags;  // {hsync, vsync, hblank, vblank, de, frame_start}
  } exp_t;

  logic clk = 1'b0;
  logic reset, ce_pix, scanlines;
  always #5 clk = ~clk;

  vfd_video_out_if vif_f ();
  vfd_video_out_if vif_s ();

  logic [7:0] r_f, g_f, b_f, r_s, g_s, b_s;
  logic hs_f, vs_f, hb_f, vb_f, de_f, fs_f;
  logic hs_s, vs_s, hb_s, vb_s, de_s, fs_s;

  vfd_video_out dut_f (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .vram(vif_f), .scanlines(scanlines),
    .r(r_f), .g(g_f), .b(b_f), .hsync(hs_f), .vsync(vs_f),
    .hblank(hb_f), .vblank(vb_f), .de(de_f), .frame_start(fs_f)
  );

  // Tiny raster so whole frames, vsync and address wrap fit in a short run.
  vfd_video_out #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_s (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .vram(vif_s), .scanlines(scanlines),
    .r(r_s), .g(g_s), .b(b_s), .hsync(hs_s), .vsync(vs_s),
    .hblank(hb_s), .vblank(vb_s), .de(de_s), .frame_start(fs_s)
  );

  logic [7:0] mem [0:307199];

  always @(posedge clk) begin
    vif_f.vram_data <= mem[vif_f.vram_addr];
    vif_s.vram_data <= mem[vif_s.vram_addr];
  end

  int checks = 0;
  int errors = 0;
  int k = 0;
  int de_cnt = 0, hs_low = 0, first_de = -1, first_hs = -1, last_fs = -1;
  bit phase1 = 1'b0;
  logic [23:0] first_px [4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h9292AA};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (tick %0d)", tag, got, exp, k);
    end
  endtask

  // Output after tick k shows raster position k-2; the address after tick k
  // belongs to position k-1 (held at the last visible address in blanking).
  function automatic exp_t model(input int kk, input bit tick, input bit scan,
                                 input int ha, input int hf, input int hs, input int hb,
                                 input int va, input int vf, input int vs, input int vb);
    exp_t e;
    int ht, fr, q, h, v, d, rr, gg, bb;
    ht = ha + hf + hs + hb;
    fr = ht * (va + vf + vs + vb);
    e.rgb = '0;
    e.addr = '0;
    e.flags = 6'b111100;
    if (kk >= 1) begin
      q = (kk - 1) % fr; h = q % ht; v = q / ht;
      if (v >= va)      e.addr = 19'(ha * va - 1);
      else if (h >= ha) e.addr = 19'(v * ha + ha - 1);
      else              e.addr = 19'(v * ha + h);
    end
    if (kk >= 2) begin
      q = (kk - 2) % fr; h = q % ht; v = q / ht;
      e.flags[5] = !(h >= ha + hf && h < ha + hf + hs);
      e.flags[4] = !(v >= va + vf && v < va + vf + vs);
      e.flags[3] = (h >= ha);
      e.flags[2] = (v >= va);
      e.flags[1] = (h < ha) && (v < va);
      e.flags[0] = tick && (q == 0);
      if (h < ha && v < va) begin
        d  = int'(mem[v * ha + h]);
        rr = d / 32; gg = (d / 4) % 8; bb = d % 4;
        rr = rr * 32 + rr * 4 + rr / 2;
        gg = gg * 32 + gg * 4 + gg / 2;
        bb = bb * 85;
        if (SCAN_EN && scan && (v % 2 == 1)) begin
          rr = rr / 2; gg = gg / 2; bb = bb / 2;
        end
        e.rgb = 24'(rr * 65536 + gg * 256 + bb);
      end
    end
    return e;
  endfunction

  task automatic step();
    bit tick;
    exp_t ef, es;
    @(posedge clk);
    tick = !reset && ce_pix;
    if (reset) begin
      k = 0;
      last_fs = -1;
    end else if (ce_pix) k++;
    #1;
    ef = model(k, tick, scanlines, 640, 16, 96, 48, 480, 10, 2, 33);
    es = model(k, tick, scanlines, 8, 2, 3, 3, 6, 1, 2, 1);
    check("full_rgb",    {8'd0, r_f, g_f, b_f}, {8'd0, ef.rgb});
    check("full_addr",   {13'd0, vif_f.vram_addr}, {13'd0, ef.addr});
    check("full_flags",  {26'd0, hs_f, vs_f, hb_f, vb_f, de_f, fs_f}, {26'd0, ef.flags});
    check("small_rgb",   {8'd0, r_s, g_s, b_s}, {8'd0, es.rgb});
    check("small_addr",  {13'd0, vif_s.vram_addr}, {13'd0, es.addr});
    check("small_flags", {26'd0, hs_s, vs_s, hb_s, vb_s, de_s, fs_s}, {26'd0, es.flags});

    if (tick && phase1) begin
      if (k >= 2 && k <= 5)
        check("first_px", {8'd0, r_f, g_f, b_f}, {8'd0, first_px[k-2]});
      if (k == 6)
        check("scan_line0", {8'd0, r_f, g_f, b_f}, 32'h00FFFFFF);
      if (k == 802)
        check("scan_line1", {8'd0, r_f, g_f, b_f}, SCAN_EN ? 32'h007F7F7F : 32'h00FFFFFF);
      if (k >= 2 && k <= 801) begin
        if (de_f) begin
          de_cnt++;
          if (first_de < 0) first_de = k;
        end
        if (!hs_f) begin
          hs_low++;
          if (first_hs < 0) first_hs = k;
        end
      end
    end
    if (tick && fs_s) begin
      if (last_fs >= 0) check("small_frame_period", k - last_fs, 160);
      last_fs = k;
    end

    @(negedge clk);
    ce_pix = ce_pix ? 1'b0 : ($urandom_range(0, 3) != 0);
  endtask

  task automatic run_until(input int target);
    int guard = 0;
    while (k < target && guard < 20000) begin
      step();
      guard++;
    end
    if (k < target) check("tick_budget", k, target);
  endtask

  initial begin
    for (int i = 0; i < 307200; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hE0; mem[1] = 8'h1C; mem[2] = 8'h03; mem[3] = 8'h92;
    mem[4] = 8'hFF; mem[640] = 8'hFF;

    reset = 1'b1;
    ce_pix = 1'b0;
    scanlines = 1'b1;
    repeat (6) step();
    reset = 1'b0;
    phase1 = 1'b1;

    // Stop with the full-size output at line 2, pixel 300.
    run_until(1902);
    phase1 = 1'b0;
    check("line_de_count", de_cnt, 640);
    check("line_hsync_low", hs_low, 96);
    check("hsync_offset", first_hs - first_de, 656);

    reset = 1'b1;
    scanlines = 1'b0;
    repeat (4) step();
    reset = 1'b0;
    run_until(1700);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
